xorshift_checker: RTL and testbench



---
 rtl/xorshift_pkg.sv | 31 +++
 rtl/sat_counter.sv | 30 +++
 rtl/xorshift_checker.sv | 121 ++++++++++++
 tb/tb_xorshift_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/xorshift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xorshift_pkg
//  Purpose  : Seeds, shift amounts, recurrence and FSM type shared by the
//             xorshift128 generator and checker.
//  Revision : 1.0  initial release
// ============================================================================
package xorshift_pkg;

  localparam logic [31:0] c_SEED_X = 32'd123456789;
  localparam logic [31:0] c_SEED_Y = 32'd362436069;
  localparam logic [31:0] c_SEED_Z = 32'd521288629;
  localparam logic [31:0] c_SEED_W = 32'd88675123;

  localparam int unsigned c_SH_A = 11;
  localparam int unsigned c_SH_B = 8;
  localparam int unsigned c_SH_C = 19;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic [31:0] xorshift_next(input logic [31:0] x, input logic [31:0] w);
    logic [31:0] t;
    t = x ^ (x << c_SH_A);
    return w ^ (w >> c_SH_C) ^ t ^ (t >> c_SH_B);
  endfunction

endpackage : xorshift_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at all-ones; clear beats increment.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/xorshift_checker.sv
`default_nettype none
// ============================================================================
//  Module   : xorshift_checker
//  Purpose  : Locks onto an xorshift128 word stream and flags mispredicted
//             words, keeping saturating match/error statistics.
//  Revision : 1.0  initial release
// ============================================================================
module xorshift_checker
  import xorshift_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned        c_RUN_W   = $clog2(ERR_LIMIT + 1);
  localparam logic [c_RUN_W-1:0] c_ERR_LIM = c_RUN_W'(ERR_LIMIT);

  chk_state_t         state_q;
  logic [31:0]        x_q, y_q, z_q, w_q;
  logic [1:0]         fill_q;
  logic [c_RUN_W-1:0] run_q;
  logic               ready_q;
  logic               err_pulse_q;

  logic        w_accept;
  logic [31:0] w_pred;
  logic        w_match;
  logic        w_match_inc;
  logic        w_err_inc;

  assign w_accept    = in_valid && ready_q;
  assign w_pred      = xorshift_next(x_q, w_q);
  assign w_match     = (in_data == w_pred);
  assign w_match_inc = w_accept && (state_q == LOCKED) && w_match;
  assign w_err_inc   = w_accept && (state_q == LOCKED) && !w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      w_q         <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      ready_q     <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      err_pulse_q <= 1'b0;
      if (w_accept) begin
        x_q <= y_q;
        y_q <= z_q;
        z_q <= w_q;
        case (state_q)
          HUNT: begin
            w_q <= in_data;
            if (fill_q == 2'd3) begin
              fill_q <= '0;
              // An all-zero history is a fixed point of the recurrence, not a state.
              if ((y_q | z_q | w_q | in_data) != 32'd0) begin
                state_q <= LOCKED;
              end
            end else begin
              fill_q <= fill_q + 2'd1;
            end
          end
          LOCKED: begin
            w_q <= w_pred;
            if (w_match) begin
              run_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (run_q + c_RUN_W'(1) == c_ERR_LIM) begin
                run_q   <= '0;
                fill_q  <= '0;
                state_q <= HUNT;
              end else begin
                run_q <= run_q + c_RUN_W'(1);
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_match_inc),
    .clr   (clear),
    .count (match_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_err_inc),
    .clr   (clear),
    .count (err_count)
  );

  assign in_ready  = ready_q;
  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

endmodule : xorshift_checker
`default_nettype wire

// File: tb/tb_xorshift_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xorshift_checker
//  Purpose  : Directed self-checking bench for xorshift_checker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xorshift_checker;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  // First words of the reference generator from the standard seeds.
  logic [31:0] seeds [4] = '{32'd123456789, 32'd362436069, 32'd521288629, 32'd88675123};
  logic [31:0] outs  [4] = '{32'd3701687786, 32'd458299110, 32'd2500872618, 32'd3418158144};

  always #5 clk = ~clk;

  xorshift_checker #(.ERR_LIMIT(4), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .clear       (clear),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .match_count (match_count),
    .err_count   (err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic clr);
    in_valid = 1'b1;
    in_data  = d;
    clear    = clr;
    step();
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic send_seeds();
    for (int i = 0; i < 4; i++) send(seeds[i], 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    clear    = 1'b0;
    step();
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_match", match_count, 0);
    check("rst_err", err_count, 0);
    check("rst_ready", in_ready, 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", in_ready, 1);

    // Acquire and match
    for (int i = 0; i < 3; i++) send(seeds[i], 1'b0);
    check("t1_not_locked_3", locked, 0);
    send(seeds[3], 1'b0);
    check("t1_locked_4", locked, 1);
    for (int i = 0; i < 3; i++) begin
      send(outs[i], 1'b0);
      check("t1_no_err_pulse", err_pulse, 0);
    end
    check("t1_match_count", match_count, 3);
    check("t1_err_count", err_count, 0);
    check("t1_still_locked", locked, 1);

    // Single corruption
    do_reset();
    send_seeds();
    send(outs[0], 1'b0);
    send(32'd458299111, 1'b0);
    check("t2_err_pulse", err_pulse, 1);
    check("t2_err_count", err_count, 1);
    check("t2_lock_held", locked, 1);
    send(outs[2], 1'b0);
    check("t2_pulse_clear", err_pulse, 0);
    check("t2_match_count", match_count, 2);
    check("t2_err_count_hold", err_count, 1);

    // Loss of lock after four consecutive mismatches
    do_reset();
    send_seeds();
    for (int i = 0; i < 3; i++) send(32'd0, 1'b0);
    check("t3_locked_after_3", locked, 1);
    check("t3_err_count_3", err_count, 3);
    send(32'd0, 1'b0);
    check("t3_unlocked", locked, 0);
    check("t3_err_pulse_4", err_pulse, 1);
    check("t3_err_count_4", err_count, 4);
    send_seeds();
    check("t3_relocked", locked, 1);
    check("t3_err_count_hunt", err_count, 4);
    send(outs[0], 1'b0);
    check("t3_match_after_relock", match_count, 1);

    // All-zero hunt
    do_reset();
    for (int i = 0; i < 4; i++) send(32'd0, 1'b0);
    check("t4_zero_not_locked", locked, 0);
    idle(1);
    check("t4_zero_still_unlocked", locked, 0);
    send_seeds();
    check("t4_seed_locked", locked, 1);

    // Gaps and clear
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      send(seeds[i], 1'b0);
    end
    check("t5_locked", locked, 1);
    idle($urandom_range(1, 3));
    check("t5_lock_in_gap", locked, 1);
    send(outs[0], 1'b0);
    check("t5_match_1", match_count, 1);
    idle($urandom_range(1, 3));
    send(outs[1], 1'b1);
    check("t5_cleared", match_count, 0);
    check("t5_clear_no_pulse", err_pulse, 0);
    idle($urandom_range(1, 3));
    send(outs[2], 1'b0);
    check("t5_match_after_clear", match_count, 1);
    check("t5_err_count", err_count, 0);
    check("t5_locked_end", locked, 1);

    // Reset mid-lock with nonzero counters
    send(32'd1, 1'b0);
    check("t6_err_before_rst", err_count, 1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = outs[3];
    step();
    check("t6_rst_locked", locked, 0);
    check("t6_rst_match", match_count, 0);
    check("t6_rst_err", err_count, 0);
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_pulse", err_pulse, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_xorshift_checker
`default_nettype wire
